// File: rtl/demux_stream.sv
// 1:4 stream demultiplexer: one valid/ready input routed by {s1,s0} into four
// independent per-channel FIFOs, each with its own valid/ready-style output.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s1,
  input  logic               s0,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         v,
  input  logic [3:0]         r,
  output logic [4*WIDTH-1:0] y,
  output logic [4*CW-1:0]    cnt
);

  logic [1:0]    sel;
  logic [CW-1:0] count_all [4];

  assign sel      = {s1, s0};
  // Readiness comes only from registered occupancy, so there is no r -> in_ready path.
  assign in_ready = (count_all[sel] != CW'(DEPTH));

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready && (sel == 2'(k));
    assign pop  = r[k] && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end

    assign count_all[k]          = count;
    assign v[k]                  = (count != '0);
    assign y[k*WIDTH +: WIDTH]   = v[k] ? mem[rd_ptr] : '0;
    assign cnt[k*CW +: CW]       = count;
  end

endmodule
